alu_seq: RTL and testbench

- Registered, handshaked successor to the combinational Game Boy ALU, parametrised in datapath width.
- Owns the architectural flag register F = {Z,N,H,C}, so ADC/SBC/DAA/CCF read carry state internally.
- Adds CB-prefix shift/rotate ops, DAA/CPL/SCF/CCF, and a two-pass double-width add (ADD HL,rr).
- Sits between the decoder/sequencer and the register file.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_slice.sv | 110 +++++++++++
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the sequential Game Boy ALU.
//   - 5-bit opcode encodings (ADD..ADDW, 21-31 illegal)
//   - bit positions of Z/N/H/C inside the 4-bit F register
//   - FSM state encoding for alu_seq
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBC  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_CP   = 5'd7;
  localparam logic [4:0] OP_RLC  = 5'd8;
  localparam logic [4:0] OP_RRC  = 5'd9;
  localparam logic [4:0] OP_RL   = 5'd10;
  localparam logic [4:0] OP_RR   = 5'd11;
  localparam logic [4:0] OP_SLA  = 5'd12;
  localparam logic [4:0] OP_SRA  = 5'd13;
  localparam logic [4:0] OP_SWAP = 5'd14;
  localparam logic [4:0] OP_SRL  = 5'd15;
  localparam logic [4:0] OP_DAA  = 5'd16;
  localparam logic [4:0] OP_CPL  = 5'd17;
  localparam logic [4:0] OP_SCF  = 5'd18;
  localparam logic [4:0] OP_CCF  = 5'd19;
  localparam logic [4:0] OP_ADDW = 5'd20;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC_HI = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational DATA_W-wide ALU slice.
//   a, b  : operands            op   : opcode (alu_pkg)
//   cin   : carry-in, used only by ADDW (high pass of the wide add)
//   fin   : current F register {Z,N,H,C}
//   res   : slice result        z/n/h/c : new flag values
//   cout  : carry out of the MSB of a+b+cin (latched between ADDW passes)
// Ops that leave a flag untouched pass the fin bit through, so the caller can
// write all four flags unconditionally. Illegal opcodes return a, flags = fin.
// HALF_BIT must be below DATA_W.
module alu_slice
  import alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HALF_BIT = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        op,
  input  logic              cin,
  input  logic [3:0]        fin,
  output logic [DATA_W-1:0] res,
  output logic              z,
  output logic              n,
  output logic              h,
  output logic              c,
  output logic              cout
);

  localparam int HW = DATA_W / 2;

  logic              ci;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic              hc_add;
  logic              hc_sub;

  always_comb begin
    unique case (op)
      OP_ADC, OP_SBC: ci = fin[FLAG_C];
      OP_ADDW:        ci = cin;
      default:        ci = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(ci);
    dif = {1'b0, a} - {1'b0, b} - (DATA_W+1)'(ci);
    // Carry/borrow into bit HALF_BIT recovered from the sum bit itself.
    hc_add = sum[HALF_BIT] ^ a[HALF_BIT] ^ b[HALF_BIT];
    hc_sub = dif[HALF_BIT] ^ a[HALF_BIT] ^ b[HALF_BIT];
  end

  assign cout = sum[DATA_W];

  always_comb begin
    res = a;
    z   = fin[FLAG_Z];
    n   = fin[FLAG_N];
    h   = fin[FLAG_H];
    c   = fin[FLAG_C];
    unique case (op)
      OP_ADD, OP_ADC: begin
        res = sum[DATA_W-1:0];
        z = ~|res; n = 1'b0; h = hc_add; c = sum[DATA_W];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        // CP keeps A as the result but flags reflect the subtraction.
        res = (op == OP_CP) ? a : dif[DATA_W-1:0];
        z = ~|dif[DATA_W-1:0]; n = 1'b1; h = hc_sub; c = dif[DATA_W];
      end
      OP_AND: begin res = a & b; z = ~|res; n = 1'b0; h = 1'b1; c = 1'b0; end
      OP_OR:  begin res = a | b; z = ~|res; n = 1'b0; h = 1'b0; c = 1'b0; end
      OP_XOR: begin res = a ^ b; z = ~|res; n = 1'b0; h = 1'b0; c = 1'b0; end
      OP_RLC:  begin res = {a[DATA_W-2:0], a[DATA_W-1]};      c = a[DATA_W-1]; end
      OP_RRC:  begin res = {a[0], a[DATA_W-1:1]};             c = a[0];        end
      OP_RL:   begin res = {a[DATA_W-2:0], fin[FLAG_C]};      c = a[DATA_W-1]; end
      OP_RR:   begin res = {fin[FLAG_C], a[DATA_W-1:1]};      c = a[0];        end
      OP_SLA:  begin res = {a[DATA_W-2:0], 1'b0};             c = a[DATA_W-1]; end
      OP_SRA:  begin res = {a[DATA_W-1], a[DATA_W-1:1]};      c = a[0];        end
      OP_SWAP: begin res = {a[HW-1:0], a[DATA_W-1:HW]};       c = 1'b0;        end
      OP_SRL:  begin res = {1'b0, a[DATA_W-1:1]};             c = a[0];        end
      OP_DAA: begin
        // BCD correction is only meaningful for byte-wide slices; other
        // widths fall back to the illegal-op behaviour (defaults above).
        if (DATA_W == 8) begin
          if (!fin[FLAG_N]) begin
            if (fin[FLAG_C] || a > DATA_W'(8'h99)) begin
              res = res + DATA_W'(8'h60);
              c   = 1'b1;
            end
            if (fin[FLAG_H] || a[3:0] > 4'h9) res = res + DATA_W'(8'h06);
          end else begin
            if (fin[FLAG_C]) res = res - DATA_W'(8'h60);
            if (fin[FLAG_H]) res = res - DATA_W'(8'h06);
          end
          z = ~|res; h = 1'b0;
        end
      end
      OP_CPL:  begin res = ~a; n = 1'b1; h = 1'b1; end
      OP_SCF:  begin n = 1'b0; h = 1'b0; c = 1'b1; end
      OP_CCF:  begin n = 1'b0; h = 1'b0; c = ~fin[FLAG_C]; end
      OP_ADDW: begin
        // Z untouched; H/C only matter from the high pass.
        res = sum[DATA_W-1:0]; n = 1'b0; h = hc_add; c = sum[DATA_W];
      end
      default: ;
    endcase
    if (op inside {[OP_RLC:OP_SRL]}) begin
      z = ~|res; n = 1'b0; h = 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready Game Boy ALU owning the F register.
//   clk, rst          : clock, asynchronous active-high reset
//   inValid/inReady   : request handshake (inReady only in IDLE)
//   opcode            : operation (alu_pkg OP_*)
//   operandA/operandB : 2*DATA_W operands; narrow ops use the low slice
//   outValid/outReady : result handshake (outValid only in DONE)
//   result            : 2*DATA_W result, narrow results zero-extended
//   flags             : F = {Z,N,H,C}
// Optional build macro ALU_FLAG_LOAD_EN adds flagLoad/flagIn (POP AF): in IDLE
// a load overrides F, and an op accepted on the same edge sees the loaded F.
// Narrow ops are computed directly from the live operands on the accept edge;
// ADDW uses the same slice twice, latching the low carry between passes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int         DATA_W     = 8,
  parameter int         HALF_BIT   = 4,
  parameter logic [3:0] FLAG_RESET = 4'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inValid,
  output logic                inReady,
  input  logic [4:0]          opcode,
  input  logic [2*DATA_W-1:0] operandA,
  input  logic [2*DATA_W-1:0] operandB,
  output logic                outValid,
  input  logic                outReady,
  output logic [2*DATA_W-1:0] result,
  output logic [3:0]          flags
`ifdef ALU_FLAG_LOAD_EN
  ,
  input  logic                flagLoad,
  input  logic [3:0]          flagIn
`endif
);

  state_t            state, state_nxt;
  logic              accept;
  logic [3:0]        f_q, f_eff;
  logic [DATA_W-1:0] ahi_q, bhi_q;
  logic              carry_q;

  logic [DATA_W-1:0] s_a, s_b, s_res;
  logic [4:0]        s_op;
  logic              s_cin, s_z, s_n, s_h, s_c, s_cout;

  assign accept = inValid && inReady;
  assign flags  = f_q;

`ifdef ALU_FLAG_LOAD_EN
  assign f_eff = (flagLoad && state == ST_IDLE) ? flagIn : f_q;
`else
  assign f_eff = f_q;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (accept) state_nxt = (opcode == OP_ADDW) ? ST_EXEC_HI : ST_DONE;
      ST_EXEC_HI: state_nxt = ST_DONE;
      ST_DONE:    if (outReady) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // outputs and slice input steering
  always_comb begin
    inReady  = (state == ST_IDLE);
    outValid = (state == ST_DONE);
    if (state == ST_EXEC_HI) begin
      s_a   = ahi_q;
      s_b   = bhi_q;
      s_op  = OP_ADDW;
      s_cin = carry_q;
    end else begin
      s_a   = operandA[DATA_W-1:0];
      s_b   = operandB[DATA_W-1:0];
      s_op  = opcode;
      s_cin = 1'b0;
    end
  end

  alu_slice #(
    .DATA_W   (DATA_W),
    .HALF_BIT (HALF_BIT)
  ) u_slice (
    .a    (s_a),
    .b    (s_b),
    .op   (s_op),
    .cin  (s_cin),
    .fin  (f_eff),
    .res  (s_res),
    .z    (s_z),
    .n    (s_n),
    .h    (s_h),
    .c    (s_c),
    .cout (s_cout)
  );

  // datapath: result, F, ADDW high-pass operands and carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      f_q     <= FLAG_RESET;
      ahi_q   <= '0;
      bhi_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // f_eff already carries any same-cycle flag load.
          f_q <= (accept && opcode != OP_ADDW) ? {s_z, s_n, s_h, s_c} : f_eff;
          if (accept) begin
            result  <= {{DATA_W{1'b0}}, s_res};
            ahi_q   <= operandA[2*DATA_W-1:DATA_W];
            bhi_q   <= operandB[2*DATA_W-1:DATA_W];
            carry_q <= s_cout;
          end
        end
        ST_EXEC_HI: begin
          result[2*DATA_W-1:DATA_W] <= s_res;
          f_q <= {s_z, s_n, s_h, s_c};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  opcode = '0;
  logic [15:0] operandA = '0;
  logic [15:0] operandB = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] result;
  logic [3:0]  flags;
`ifdef ALU_FLAG_LOAD_EN
  logic        flagLoad = 1'b0;
  logic [3:0]  flagIn = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] mf = 4'h0;   // model of F

  alu_seq #(.DATA_W(8), .HALF_BIT(4), .FLAG_RESET(4'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .opcode   (opcode),
    .operandA (operandA),
    .operandB (operandB),
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .flags    (flags)
`ifdef ALU_FLAG_LOAD_EN
    ,
    .flagLoad (flagLoad),
    .flagIn   (flagIn)
`endif
  );

  always #5 clk = ~clk;

  // Reference model for 8-bit ops, plain integer arithmetic on Game Boy rules.
  function automatic int ref_narrow(input int op, input int a16, input int b16,
                                    input logic [3:0] fi, output logic [3:0] fo);
    int a, b, c, t, r;
    logic z, n, h, cy;
    a = a16 & 255; b = b16 & 255; c = fi[0] ? 1 : 0;
    z = fi[3]; n = fi[2]; h = fi[1]; cy = fi[0]; r = a;
    case (op)
      0, 1: begin
        if (op == 0) c = 0;
        t = a + b + c; r = t & 255;
        z = (r == 0); n = 1'b0; h = ((a & 15) + (b & 15) + c) > 15; cy = (t > 255);
      end
      2, 3, 7: begin
        if (op != 3) c = 0;
        t = a - b - c; r = (op == 7) ? a : (t & 255);
        z = ((t & 255) == 0); n = 1'b1; h = ((a & 15) - (b & 15) - c) < 0; cy = (t < 0);
      end
      4: begin r = a & b; z = (r == 0); n = 1'b0; h = 1'b1; cy = 1'b0; end
      5: begin r = a | b; z = (r == 0); n = 1'b0; h = 1'b0; cy = 1'b0; end
      6: begin r = a ^ b; z = (r == 0); n = 1'b0; h = 1'b0; cy = 1'b0; end
      8:  begin r = ((a * 2) + (a / 128)) & 255; cy = (a >= 128); end
      9:  begin r = (a / 2) + (a % 2) * 128;     cy = (a % 2 == 1); end
      10: begin r = ((a * 2) + c) & 255;         cy = (a >= 128); end
      11: begin r = (a / 2) + c * 128;           cy = (a % 2 == 1); end
      12: begin r = (a * 2) & 255;               cy = (a >= 128); end
      13: begin r = (a / 2) + (a & 128);         cy = (a % 2 == 1); end
      14: begin r = (a % 16) * 16 + a / 16;      cy = 1'b0; end
      15: begin r = a / 2;                       cy = (a % 2 == 1); end
      16: begin
        t = a;
        if (!n) begin
          if (cy || a > 153) begin t = t + 96; cy = 1'b1; end
          if (h || (a % 16) > 9) t = t + 6;
        end else begin
          if (cy) t = t - 96;
          if (h) t = t - 6;
        end
        r = t & 255; z = (r == 0); h = 1'b0;
      end
      17: begin r = 255 - a; n = 1'b1; h = 1'b1; end
      18: begin n = 1'b0; h = 1'b0; cy = 1'b1; end
      19: begin n = 1'b0; h = 1'b0; cy = !cy; end
      default: ;
    endcase
    if (op >= 8 && op <= 15) begin z = (r == 0); n = 1'b0; h = 1'b0; end
    fo = {z, n, h, cy};
    return r;
  endfunction

  // 16-bit add: H from bit 11, C from bit 15, Z kept.
  function automatic int ref_wide(input int a, input int b, input logic [3:0] fi,
                                  output logic [3:0] fo);
    int s;
    s = a + b;
    fo = {fi[3], 1'b0, ((a % 4096) + (b % 4096)) > 4095, s > 65535};
    return s % 65536;
  endfunction

  // One full transaction with outReady high; lat counts edges accept->outValid.
  task automatic do_op(input int op, input int a, input int b,
                       output int r, output logic [3:0] f, output int lat);
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("FAIL inReady_idle got=%b want=1", inReady);
    end
    inValid = 1'b1; opcode = 5'(op); operandA = 16'(a); operandB = 16'(b);
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 1;
    while (outValid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    r = int'(result); f = flags;
    checks++;
    if (outValid !== 1'b1) begin
      errors++; $display("FAIL outValid_timeout op=%0d got=%b want=1", op, outValid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({inReady, outValid} !== 2'b10 || result !== 16'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h f=%b want rdy=1 vld=0 res=0000 f=0000",
               inReady, outValid, result, flags);
    end
    @(negedge clk); rst = 1'b0;
    mf = 4'h0;
  endtask

  task automatic test_directed();
    int          t_op [11] = '{0, 2, 3, 6, 20, 0, 16, 10, 7, 17, 25};
    int          t_a  [11] = '{'h0F, 'h10, 'h00, 'h55, 'h0FFF, 'h45, 'h7D, 'h80, 'h42, 'h5A, 'h1234};
    int          t_b  [11] = '{'h01, 'h20, 'h00, 'h55, 'h0001, 'h38, 'h00, 'h00, 'h42, 'h00, 'h0000};
    int          t_r  [11] = '{'h10, 'hF0, 'hFF, 'h00, 'h1000, 'h7D, 'h83, 'h00, 'h42, 'hA5, 'h34};
    logic [3:0]  t_f  [11] = '{4'b0010, 4'b0101, 4'b0111, 4'b1000, 4'b1010, 4'b0000,
                               4'b0000, 4'b1001, 4'b1100, 4'b1110, 4'b1110};
    int r, lat;
    logic [3:0] f;
    for (int i = 0; i < 11; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], r, f, lat);
      checks++;
      if (r !== t_r[i] || f !== t_f[i] || lat !== ((t_op[i] == 20) ? 2 : 1)) begin
        errors++;
        $display("FAIL directed_%0d op=%0d got res=%h f=%b lat=%0d want res=%h f=%b lat=%0d",
                 i, t_op[i], r, f, lat, t_r[i], t_f[i], (t_op[i] == 20) ? 2 : 1);
      end
    end
    mf = t_f[10];
  endtask

  task automatic test_random();
    int op, a, b, r, lat, er, el;
    logic [3:0] f, ef;
    for (int i = 0; i < 300; i++) begin
      op = (i % 5 == 0) ? 20 : int'($urandom_range(0, 31));
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      if (op == 20) begin er = ref_wide(a, b, mf, ef); el = 2; end
      else          begin er = ref_narrow(op, a, b, mf, ef); el = 1; end
      do_op(op, a, b, r, f, lat);
      checks++;
      if (r !== er || f !== ef || lat !== el) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h fin=%b got res=%h f=%b lat=%0d want res=%h f=%b lat=%0d",
                 i, op, a, b, mf, r, f, lat, er, ef, el);
      end
      mf = ef;
    end
  endtask

  task automatic test_backpressure();
    int er, n;
    logic [3:0] ef;
    er = ref_narrow(4, 'h3C, 'h0F, mf, ef);
    outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b1; opcode = 5'd4; operandA = 16'h003C; operandB = 16'h000F;
    @(posedge clk); #1;
    inValid = 1'b0;
    n = 0;
    while (outValid !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outValid !== 1'b1 || inReady !== 1'b0 || int'(result) !== er || flags !== ef) begin
        errors++;
        $display("FAIL hold_%0d got vld=%b rdy=%b res=%h f=%b want vld=1 rdy=0 res=%h f=%b",
                 i, outValid, inReady, result, flags, er, ef);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); outReady = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("FAIL release got vld=%b rdy=%b want vld=0 rdy=1", outValid, inReady);
    end
    mf = ef;
  endtask

  task automatic test_reset_mid_addw();
    int r, lat;
    logic [3:0] f;
    do_op(18, 0, 0, r, f, lat);   // SCF so F differs from the reset value
    checks++;
    if (f !== {mf[3], 3'b001}) begin
      errors++; $display("FAIL scf_flags got=%b want=%b", f, {mf[3], 3'b001});
    end
    @(negedge clk);
    inValid = 1'b1; opcode = 5'd20; operandA = 16'hFFFF; operandB = 16'h0001;
    @(posedge clk); #1;
    inValid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (outValid !== 1'b0 || flags !== 4'h0) begin
      errors++; $display("FAIL reset_abort got vld=%b f=%b want vld=0 f=0000", outValid, flags);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1 || flags !== 4'h0) begin
        errors++;
        $display("FAIL post_reset_%0d got vld=%b rdy=%b f=%b want vld=0 rdy=1 f=0000",
                 i, outValid, inReady, flags);
      end
    end
    mf = 4'h0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_addw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
